// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared state encoding and counter sizing for the digit-serial adder
package digit_serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/digit_adder_cell.sv
// digit_adder_cell: DIGIT-bit ripple of full adders, exposing the carry into the top bit for overflow
module digit_adder_cell #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock with a registered inter-digit carry
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  state_t           state;
  logic [WIDTH-1:0] ar, br;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d;
  logic             dco, dcm;
  digit_adder_cell #(.DIGIT(DIGIT)) u_cell (
    .x       (ar[DIGIT-1:0]),
    .y       (br[DIGIT-1:0]),
    .ci      (carry),
    .s       (d),
    .co      (dco),
    .c_msb_in(dcm)
  );
  assign ready = state == ST_IDLE;
  assign busy  = state == ST_RUN;
  assign done  = state == ST_DONE;
  // new digits enter at the MSB so digit 0 lands at the bottom after N shifts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      ar       <= '0;
      br       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (start) begin
            ar    <= a;
            br    <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        ST_RUN: begin
          sum   <= WIDTH'({d, sum} >> DIGIT);
          ar    <= ar >> DIGIT;
          br    <= br >> DIGIT;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state    <= ST_DONE;
            cout     <= dco;
            overflow <= dco ^ dcm;
          end
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vector table, handshake/reset corner sequences and per-parameter random sweeps
module tb_digit_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n, start, cin, sub, ready, busy, done, cout, overflow;
  logic [7:0] a, b, sum;
  logic       go = 1'b0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                        output int lat, output int bz);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
    bz = int'(busy);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bz++;
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       ci, sb;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 2) ? 16 : 8;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : 4;
    logic         st, ci, sb, rdy, bsy, dn, co, ov, eo, ec, f;
    logic [W-1:0] aa, bb, sm, es;
    logic [W:0]   full;
    int           lat;
    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u (
      .clk(clk), .rst_n(rst_n), .start(st), .a(aa), .b(bb), .cin(ci), .sub(sb),
      .ready(rdy), .busy(bsy), .done(dn), .sum(sm), .cout(co), .overflow(ov)
    );
    initial begin
      st = 1'b0; aa = '0; bb = '0; ci = 1'b0; sb = 1'b0; f = 1'b0;
      wait (go);
      for (int k = 0; k < 1000; k++) begin
        @(posedge clk); #1;
        aa = W'($urandom); bb = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
        full = sb ? {1'b0, aa} - {1'b0, bb} : {1'b0, aa} + {1'b0, bb} + (W+1)'(ci);
        es = full[W-1:0];
        ec = sb ? ~full[W] : full[W];
        eo = (sb ? aa[W-1] != bb[W-1] : aa[W-1] == bb[W-1]) && es[W-1] != aa[W-1];
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0; aa = ~aa; bb = ~bb; sb = ~sb;
        lat = 0;
        while (!dn && lat < W + 4) begin
          @(posedge clk); #1;
          lat++;
        end
        chk($sformatf("sw%0d_%0d_lat", W, D), 32'(lat), 32'(W / D));
        chk($sformatf("sw%0d_%0d_sum", W, D), 32'(sm), 32'(es));
        chk($sformatf("sw%0d_%0d_cout", W, D), 32'(co), 32'(ec));
        chk($sformatf("sw%0d_%0d_ovf", W, D), 32'(ov), 32'(eo));
      end
      f = 1'b1;
    end
  end

  initial begin
    vec_t v[8];
    int   lat, bz, nd, gap, k;
    v[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    v[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    v[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    v[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    v[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    v[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    v[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    v[7] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].a, v[i].b, v[i].ci, v[i].sb, lat, bz);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 4);
      chk($sformatf("vec%0d_busy", i), 32'(bz), 4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(v[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(v[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(v[i].ov));
    end
    // start and operand noise while an operation is in flight
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    nd = 0; lat = 0;
    while (!done && lat < 20) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_lat", 32'(lat), 4);
    chk("busy_start_sum", 32'(sum), 32'h46);
    for (int i = 0; i < 4; i++) begin
      if (done) nd++;
      if (i == 1) begin
        chk("noise_ready", 32'(ready), 1);
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("noise_done_count", 32'(nd), 1);
    chk("noise_sum_hold", 32'(sum), 32'h46);
    // asynchronous reset two cycles into RUN
    a = 8'h55; b = 8'h11; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_cout", 32'(cout), 0);
    chk("arst_ovf", 32'(overflow), 0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst_no_done", 32'(nd), 0);
    run_op(8'h05, 8'h03, 1'b0, 1'b0, lat, bz);
    chk("post_rst_sum", 32'(sum), 32'h08);
    chk("post_rst_lat", 32'(lat), 4);
    // continuous start restarts every N+2 cycles
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!done && gap < 20);
    chk("b2b_gap", 32'(gap), 6);
    chk("b2b_sum", 32'(sum), 32'h02);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    go = 1'b1;
    k = 0;
    while (!(sw[0].f && sw[1].f && sw[2].f) && k < 40000) begin
      @(posedge clk);
      k++;
    end
    chk("sweep_finish", 32'(sw[0].f && sw[1].f && sw[2].f), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits.
- Generalises the one-bit full adder cell in width, in bits per cycle, and with an add/subtract mode.
- Sits on the datapath wherever area matters more than latency, for example accumulating sensor samples.
- Uses a start/busy/done handshake toward its controller.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be at least 2.
- DIGIT, 4: bits processed per cycle. WIDTH mod DIGIT must be 0. DIGIT=WIDTH gives single-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in for add mode; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1); captured on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; held stable from done until the next accepted start
- cout  output  1  final carry out. In sub mode, 1 means no borrow.
- overflow  output  1  two's-complement overflow of the final result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; digit counter and carry register clear to 0.
  - Outputs: sum=0, cout=0, overflow=0, done=0, busy=0, ready=1.
  - Reset asserted mid-operation aborts immediately. Partial results are discarded; no done pulse.
- Derived constant: N = WIDTH/DIGIT, the number of digit cycles.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures a, b, sub into shift registers.
  - B register loads ~b if sub=1, else b.
  - Carry register loads 1 if sub=1, else cin.
  - Counter loads 0; next state is RUN.
  - sum, cout, overflow are not cleared at this point. They are overwritten as digits complete.
- RUN, each edge E1..EN:
  - Combines the low DIGIT bits of the A and B registers with the carry register through the digit cell.
  - The resulting DIGIT-bit digit shifts into sum from the MSB side. After N edges, digit 0 occupies sum[DIGIT-1:0].
  - A and B registers shift right by DIGIT. The carry register takes the digit carry-out; the counter increments.
  - At EN (counter = N-1): next state is DONE, and cout takes the final digit carry.
  - overflow = carry into MSB XOR carry out of MSB, taken from the final digit.
- DONE:
  - done=1 for exactly one cycle, i.e. done is high N cycles after the start-sampling edge.
  - The next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE: no queuing, no effect on the operation in flight.
- a, b, sub, cin may change freely after acceptance without affecting the result.
- Arithmetic is modulo 2^WIDTH; sum never widens. In sub mode, cout is the inverted borrow.
- DIGIT=WIDTH: N=1, RUN lasts one edge, done one cycle after start.
- Back-to-back operation: start asserted continuously restarts every N+2 cycles (IDLE, RUN×N, DONE).

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a counter-width helper (clog2 of N, minimum 1).
- Sub-module digit_adder_cell: combinational, parameter DIGIT.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb_in (carry into the top bit, used for overflow).
  - Built as a DIGIT-long ripple of full-adder stages.
- The top level holds the FSM, counter, operand and result shift registers, and the carry/flag registers.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- Add, a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, overflow=1. done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Add with wrap, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0.
- Subtract, sub=1: a=0x00, b=0x01 -> sum=0xFF, cout=0, overflow=0. a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- start pulsed and operands changed during RUN and DONE -> first result unaffected and exactly one done pulse. The next operation is accepted only once ready=1.
- rst_n low at cycle 2 of RUN -> asynchronous return to IDLE, all outputs zero, no done. A subsequent 0x05+0x03 gives 0x08.
- Parameter sweep with DIGIT=1 (latency 8), DIGIT=8 (latency 1), and WIDTH=16/DIGIT=4 -> randomised 1000-operation comparison against a behavioural a±b model for sum, cout and overflow.
